// File: rtl/pad_draw_fsm.sv
// rtl/pad_draw_fsm.sv - paddle renderer: clears the framebuffer, draws a paddle and moves it on button ticks
// Every output is registered from the current state, so a write becomes visible one cycle after it is issued.
module pad_draw_fsm #(
  parameter int SCREEN_X    = 160,
  parameter int SCREEN_Y    = 120,
  parameter int PAD_W       = 16,
  parameter int PAD_H       = 4,
  parameter int PAD_Y       = 112,
  parameter int STEP        = 4,
  parameter int TICK_CYCLES = 416667,
  parameter logic [2:0] BG_COLOR  = 3'b000,
  parameter logic [2:0] PAD_COLOR = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_r,
  input  logic        btn_l,
  output logic [14:0] mem_px_addr,
  output logic [2:0]  mem_px_data,
  output logic        px_wr,
  output logic        frame_ready,
  output logic [7:0]  pad_x
);

  localparam int NPIX  = SCREEN_X * SCREEN_Y;
  localparam int MAX_X = SCREEN_X - PAD_W;
  localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [7:0] HOME_X = 8'((SCREEN_X - PAD_W) / 2);

  typedef enum logic [1:0] {CLEAR, DRAW, IDLE, ERASE} state_t;

  state_t      state, state_n;
  logic [14:0] clr_cnt, clr_cnt_n;
  logic [7:0]  row, row_n, col, col_n;
  logic [7:0]  pad_x_n, new_x, new_x_n;
  logic [14:0] addr_n;
  logic [2:0]  data_n;
  logic        wr_n, ready_n;

  logic        r_s1, r_s2, l_s1, l_s2;
  logic [TW-1:0] tick_cnt;
  logic        tick;

  logic [14:0] rect_addr;
  logic        rect_last;
  int          right_x, left_x;
  logic [7:0]  target_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      l_s1 <= 1'b0;
      l_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_r;
      r_s2 <= r_s1;
      l_s1 <= btn_l;
      l_s2 <= l_s1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Left move clamps before subtracting so pad_x never underflows.
  always_comb begin
    rect_addr = 15'((PAD_Y + int'(row)) * SCREEN_X + int'(pad_x) + int'(col));
    rect_last = (col == 8'(PAD_W - 1)) && (row == 8'(PAD_H - 1));
    right_x   = int'(pad_x) + STEP;
    if (right_x > MAX_X) right_x = MAX_X;
    left_x    = (int'(pad_x) < STEP) ? 0 : int'(pad_x) - STEP;
    target_x  = pad_x;
    if (r_s2 && !l_s2)      target_x = 8'(right_x);
    else if (l_s2 && !r_s2) target_x = 8'(left_x);
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    row_n     = row;
    col_n     = col;
    pad_x_n   = pad_x;
    new_x_n   = new_x;
    wr_n      = 1'b0;
    addr_n    = mem_px_addr;
    data_n    = mem_px_data;
    ready_n   = 1'b0;

    if (state == DRAW || state == ERASE) begin
      if (col == 8'(PAD_W - 1)) begin
        col_n = '0;
        row_n = row + 1'b1;
      end else begin
        col_n = col + 1'b1;
      end
    end

    case (state)
      CLEAR: begin
        wr_n   = 1'b1;
        addr_n = clr_cnt;
        data_n = BG_COLOR;
        if (clr_cnt == 15'(NPIX - 1)) begin
          clr_cnt_n = '0;
          row_n     = '0;
          col_n     = '0;
          state_n   = DRAW;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      DRAW: begin
        wr_n   = 1'b1;
        addr_n = rect_addr;
        data_n = PAD_COLOR;
        if (rect_last) begin
          row_n   = '0;
          col_n   = '0;
          state_n = IDLE;
        end
      end
      IDLE: begin
        ready_n = 1'b1;
        if (tick && (target_x != pad_x)) begin
          new_x_n = target_x;
          row_n   = '0;
          col_n   = '0;
          ready_n = 1'b0;
          state_n = ERASE;
        end
      end
      ERASE: begin
        wr_n   = 1'b1;
        addr_n = rect_addr;
        data_n = BG_COLOR;
        if (rect_last) begin
          row_n   = '0;
          col_n   = '0;
          pad_x_n = new_x;
          state_n = DRAW;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      row         <= '0;
      col         <= '0;
      pad_x       <= HOME_X;
      new_x       <= HOME_X;
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      frame_ready <= 1'b0;
    end else begin
      state       <= state_n;
      clr_cnt     <= clr_cnt_n;
      row         <= row_n;
      col         <= col_n;
      pad_x       <= pad_x_n;
      new_x       <= new_x_n;
      px_wr       <= wr_n;
      mem_px_addr <= addr_n;
      mem_px_data <= data_n;
      frame_ready <= ready_n;
    end
  end

endmodule
